branch_exec_unit: RTL and testbench
===================================

# branch_exec_unit

Parametrised branch/jump execution unit between the branch reservation station and the common data bus (CDB). It resolves conditional branches, JAL and JALR; computes the corrected next PC, link value and mispredict flag against the fetch-stage prediction; and buffers results in a DEPTH-entry FIFO until the CDB arbiter accepts them. It also keeps saturating branch/mispredict statistics counters.

## Interface
- XLEN, 32: data/address width
- TAG_W, 4: ROB tag width
- DEPTH, 4: result FIFO entries; power of two, at least 2
- CNT_W, 32: statistics counter width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- flush  in  1  synchronous pipeline flush from the ROB on a mispredict
- in_valid  in  1  RS issues an operation
- in_ready  out  1  unit can accept this cycle
- in_op  in  4  operation, encoded as `br_op_t`
- in_rs1, in_rs2  in  XLEN  source operands
- in_imm  in  XLEN  sign-extended offset
- in_pc  in  XLEN  instruction PC
- in_pred_taken  in  1  fetch prediction: taken
- in_pred_target  in  XLEN  fetch predicted target
- in_tag  in  TAG_W  ROB tag
- out_valid  out  1  FIFO head valid
- out_ready  in  1  CDB grant
- out_tag  out  TAG_W  head ROB tag
- out_taken  out  1  resolved direction
- out_next_pc  out  XLEN  correct next PC
- out_link  out  XLEN  PC+4 for JAL/JALR; 0 otherwise
- out_link_en  out  1  result writes rd
- out_mispredict  out  1  fetch must redirect to out_next_pc
- stat_br_cnt, stat_mp_cnt  out  CNT_W  retired-result and mispredict counts

## Operation
- Ops: BEQ, BNE, BLT, BGE (signed), BLTU, BGEU (unsigned), JAL, JALR. Any other encoding resolves as not-taken, with link_en=0 and mispredict computed normally.
- jmp = in_pc + in_imm; for JALR, jmp = (in_rs1 + in_imm) & ~1. seq = in_pc + 4. All sums are modulo 2^XLEN.
- taken = the comparison result for conditional branches; 1 for JAL/JALR.
- next_pc = taken ? jmp : seq.
- link = seq and link_en = 1 for JAL/JALR; otherwise link = 0 and link_en = 0.
- mispredict = (taken != in_pred_taken) | (taken & (jmp != in_pred_target)).
- Push happens when in_valid & in_ready & !flush. The resolved record is written at the FIFO tail.
- Pop happens when out_valid & out_ready & !flush.
- in_ready = (count < DEPTH). It does not depend on out_ready, so there is no pop-through into a full FIFO.
- Push and pop may occur in the same cycle. In that case count is unchanged and both pointers advance.
- Flush: count, head and tail pointers all go to 0. Any same-cycle push or pop is ignored. Statistics are not cleared.
- Statistics are updated on pop only:
  - stat_br_cnt += 1 per pop.
  - stat_mp_cnt += 1 per pop with mispredict = 1.
  - Both counters saturate at 2^CNT_W-1.
- Pointers are log2(DEPTH) bits and wrap naturally. Full/empty is derived from a count register of log2(DEPTH)+1 bits.

## Timing
- Latency is 1 cycle: a push at edge N makes the record visible at the head after edge N, provided the FIFO was empty.
- Outputs come directly from FIFO storage and flops. There is no combinational path from in_* to out_*.
- out_valid = (count != 0). Head fields are held stable while out_valid & !out_ready.
- Reset (rst low, asynchronous):
  - count, pointers and statistics go to 0.
  - out_valid = 0, in_ready = 1.
  - All out_* data fields read 0, because FIFO storage is reset.
- Reset deasserting mid-operation discards all buffered results.
- Flush takes effect at the next edge. out_valid is 0 in the cycle after flush.

## Structure
- Shared package `br_pkg`:
  - `br_op_t` enum (BEQ=0, BNE=1, BLT=4, BGE=5, BLTU=6, BGEU=7, JAL=8, JALR=9).
  - `br_result_t` struct {tag, taken, next_pc, link, link_en, mispredict}.
- One sub-module: `br_result_fifo` (parametrised DEPTH, payload `br_result_t`, with flush). The resolve logic stays in the top module.

## Test plan
- Reset, then BEQ with rs1=rs2=5, pc=0x100, imm=0x20, pred_taken=1, pred_target=0x120. Required next cycle: out_valid=1, taken=1, next_pc=0x120, mispredict=0, link_en=0.
- BLT rs1=0xFFFFFFFF, rs2=1 → taken. BLTU with the same operands → not taken: next_pc=pc+4, and mispredict=1 when predicted taken.
- JALR rs1=0x1003, imm=0, pc=0x200, pred_target=0x1000. Required: next_pc=0x1002, link=0x204, link_en=1, mispredict=1.
- Hold out_ready=0 and push DEPTH records. Required:
  - in_ready=0 after the DEPTH-th push.
  - A further in_valid is not accepted.
  - Records then drain in order, with tags 0..DEPTH-1.
- Full FIFO with simultaneous push and pop. Required: count unchanged and order preserved across pointer wrap. Assert flush on a later cycle with in_valid=1. Required: out_valid=0 next cycle, in_ready=1, and the flushed-cycle input is lost.
- With CNT_W=4, pop 20 mispredicted results. Required: stat_br_cnt=15 and stat_mp_cnt=15 (saturated). Assert rst mid-stream. Required: both counters and out_valid read 0 immediately, asynchronously.

Source files
------------

// File: rtl/br_pkg.sv
// br_pkg: shared op encoding and result record for the branch execution unit.
package br_pkg;
  localparam int BR_XLEN_MAX = 64;
  localparam int BR_TAG_MAX = 16;
  typedef enum logic [3:0] {
    BEQ  = 4'd0,
    BNE  = 4'd1,
    BLT  = 4'd4,
    BGE  = 4'd5,
    BLTU = 4'd6,
    BGEU = 4'd7,
    JAL  = 4'd8,
    JALR = 4'd9
  } br_op_t;
  // Fields sized for the widest supported configuration; unused upper bits are constant zero.
  typedef struct packed {
    logic [BR_TAG_MAX-1:0]  tag;
    logic                   taken;
    logic [BR_XLEN_MAX-1:0] next_pc;
    logic [BR_XLEN_MAX-1:0] link;
    logic                   link_en;
    logic                   mispredict;
  } br_result_t;
endpackage

// File: rtl/br_result_fifo.sv
// br_result_fifo: reset-cleared result FIFO with synchronous flush; no pop-through when full.
module br_result_fifo
  import br_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_flush,
  input  logic       i_push,
  input  logic       i_pop,
  input  br_result_t i_data,
  output br_result_t o_data,
  output logic       o_full,
  output logic       o_empty
);
  localparam int AW = $clog2(DEPTH);
  br_result_t    r_mem [DEPTH];
  logic [AW-1:0] r_head, r_tail;
  logic [AW:0]   r_count;
  logic          w_push, w_pop;
  assign o_full  = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_data  = r_mem[r_head];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= i_data;
        r_tail        <= r_tail + 1'b1;
      end
      if (w_pop) r_head <= r_head + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/branch_exec_unit.sv
// branch_exec_unit: resolves branches/JAL/JALR against the fetch prediction and
// queues results for the CDB, with saturating retire/mispredict statistics.
module branch_exec_unit
  import br_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [3:0]       i_in_op,
  input  logic [XLEN-1:0]  i_in_rs1,
  input  logic [XLEN-1:0]  i_in_rs2,
  input  logic [XLEN-1:0]  i_in_imm,
  input  logic [XLEN-1:0]  i_in_pc,
  input  logic             i_in_pred_taken,
  input  logic [XLEN-1:0]  i_in_pred_target,
  input  logic [TAG_W-1:0] i_in_tag,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [TAG_W-1:0] o_out_tag,
  output logic             o_out_taken,
  output logic [XLEN-1:0]  o_out_next_pc,
  output logic [XLEN-1:0]  o_out_link,
  output logic             o_out_link_en,
  output logic             o_out_mispredict,
  output logic [CNT_W-1:0] o_stat_br_cnt,
  output logic [CNT_W-1:0] o_stat_mp_cnt
);
  br_op_t            w_op;
  logic              w_is_jmp, w_taken, w_full, w_empty, w_pop;
  logic [XLEN-1:0]   w_seq, w_sum, w_jmp;
  br_result_t        w_res, w_head;
  logic [CNT_W-1:0]  r_br_cnt, r_mp_cnt;
  assign w_op     = br_op_t'(i_in_op);
  assign w_is_jmp = (w_op == JAL) | (w_op == JALR);
  assign w_seq    = i_in_pc + XLEN'(4);
  assign w_sum    = ((w_op == JALR) ? i_in_rs1 : i_in_pc) + i_in_imm;
  assign w_jmp    = (w_op == JALR) ? {w_sum[XLEN-1:1], 1'b0} : w_sum;
  always_comb begin
    w_taken = 1'b0;
    case (w_op)
      BEQ:       w_taken = i_in_rs1 == i_in_rs2;
      BNE:       w_taken = i_in_rs1 != i_in_rs2;
      BLT:       w_taken = $signed(i_in_rs1) < $signed(i_in_rs2);
      BGE:       w_taken = $signed(i_in_rs1) >= $signed(i_in_rs2);
      BLTU:      w_taken = i_in_rs1 < i_in_rs2;
      BGEU:      w_taken = i_in_rs1 >= i_in_rs2;
      JAL, JALR: w_taken = 1'b1;
      default:   w_taken = 1'b0;
    endcase
  end
  always_comb begin
    w_res            = '0;
    w_res.tag        = BR_TAG_MAX'(i_in_tag);
    w_res.taken      = w_taken;
    w_res.next_pc    = BR_XLEN_MAX'(w_taken ? w_jmp : w_seq);
    w_res.link       = BR_XLEN_MAX'(w_is_jmp ? w_seq : '0);
    w_res.link_en    = w_is_jmp;
    w_res.mispredict = (w_taken != i_in_pred_taken) | (w_taken & (w_jmp != i_in_pred_target));
  end
  br_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_flush),
    .i_push  (i_in_valid),
    .i_pop   (i_out_ready),
    .i_data  (w_res),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  assign o_in_ready       = ~w_full;
  assign o_out_valid      = ~w_empty;
  assign o_out_tag        = w_head.tag[TAG_W-1:0];
  assign o_out_taken      = w_head.taken;
  assign o_out_next_pc    = w_head.next_pc[XLEN-1:0];
  assign o_out_link       = w_head.link[XLEN-1:0];
  assign o_out_link_en    = w_head.link_en;
  assign o_out_mispredict = w_head.mispredict;
  assign o_stat_br_cnt    = r_br_cnt;
  assign o_stat_mp_cnt    = r_mp_cnt;
  assign w_pop            = ~w_empty & i_out_ready & ~i_flush;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_br_cnt <= '0;
      r_mp_cnt <= '0;
    end else if (w_pop) begin
      r_br_cnt <= (&r_br_cnt) ? r_br_cnt : r_br_cnt + 1'b1;
      if (w_head.mispredict) r_mp_cnt <= (&r_mp_cnt) ? r_mp_cnt : r_mp_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_branch_exec_unit.sv
// tb_branch_exec_unit: directed checks of resolve, FIFO flow control, flush, stats and reset.
module tb_branch_exec_unit;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, pred_taken, out_valid, out_ready;
  logic [3:0]  op, tag, out_tag;
  logic [31:0] rs1, rs2, imm, pc, pred_target, next_pc, link;
  logic        taken, link_en, mp;
  logic [3:0]  br_cnt, mp_cnt;
  int          checks = 0;
  int          errors = 0;

  branch_exec_unit #(.XLEN(32), .TAG_W(4), .DEPTH(4), .CNT_W(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_op(op),
    .i_in_rs1(rs1), .i_in_rs2(rs2), .i_in_imm(imm), .i_in_pc(pc),
    .i_in_pred_taken(pred_taken), .i_in_pred_target(pred_target), .i_in_tag(tag),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_tag(out_tag),
    .o_out_taken(taken), .o_out_next_pc(next_pc), .o_out_link(link),
    .o_out_link_en(link_en), .o_out_mispredict(mp),
    .o_stat_br_cnt(br_cnt), .o_stat_mp_cnt(mp_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] im, input logic [31:0] p, input logic pt,
                        input logic [31:0] ptg, input logic [3:0] t);
    op = o; rs1 = a; rs2 = b; imm = im; pc = p; pred_taken = pt; pred_target = ptg; tag = t;
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic [31:0] p, input logic pt,
                       input logic [31:0] ptg, input logic [3:0] t);
    set_in(o, a, b, im, p, pt, ptg, t);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic chk_head(input string name, input logic tk, input logic [31:0] npc,
                          input logic [31:0] lk, input logic le, input logic m);
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    chk({name, "_taken"}, 64'(taken), 64'(tk));
    chk({name, "_next_pc"}, 64'(next_pc), 64'(npc));
    chk({name, "_link"}, 64'(link), 64'(lk));
    chk({name, "_link_en"}, 64'(link_en), 64'(le));
    chk({name, "_mispredict"}, 64'(mp), 64'(m));
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_in(4'd0, '0, '0, '0, '0, 1'b0, '0, 4'd0);
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_next_pc", 64'(next_pc), 64'd0);
    chk("rst_stats", 64'({br_cnt, mp_cnt}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    issue(4'd0, 32'd5, 32'd5, 32'h20, 32'h100, 1'b1, 32'h120, 4'd1);
    chk_head("beq", 1'b1, 32'h120, 32'h0, 1'b0, 1'b0);
    chk("beq_tag", 64'(out_tag), 64'd1);
    pop();
    issue(4'd4, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h300, 1'b1, 32'h340, 4'd2);
    chk_head("blt", 1'b1, 32'h340, 32'h0, 1'b0, 1'b0);
    pop();
    issue(4'd6, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h300, 1'b1, 32'h340, 4'd3);
    chk_head("bltu", 1'b0, 32'h304, 32'h0, 1'b0, 1'b1);
    pop();
    issue(4'd9, 32'h1003, 32'd0, 32'h0, 32'h200, 1'b1, 32'h1000, 4'd4);
    chk_head("jalr", 1'b1, 32'h1002, 32'h204, 1'b1, 1'b1);
    pop();
    issue(4'd8, 32'd0, 32'd0, 32'hFFFF_FFF8, 32'h400, 1'b1, 32'h3F8, 4'd5);
    chk_head("jal", 1'b1, 32'h3F8, 32'h404, 1'b1, 1'b0);
    pop();
    issue(4'd5, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h500, 1'b0, 32'h0, 4'd6);
    chk_head("bge", 1'b0, 32'h504, 32'h0, 1'b0, 1'b0);
    pop();
    issue(4'd2, 32'd0, 32'd0, 32'h10, 32'h600, 1'b1, 32'h610, 4'd7);
    chk_head("badop", 1'b0, 32'h604, 32'h0, 1'b0, 1'b1);
    pop();
    chk("stat_br_7", 64'(br_cnt), 64'd7);
    chk("stat_mp_3", 64'(mp_cnt), 64'd3);
    chk("empty_after_pops", 64'(out_valid), 64'd0);

    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fill_ready_%0d", i), 64'(in_ready), 64'd1);
      issue(4'd0, 32'd1, 32'd1, 32'h8, 32'h1000 + 32'(16 * i), 1'b1, 32'h1008 + 32'(16 * i), 4'(i));
    end
    chk("full_in_ready", 64'(in_ready), 64'd0);
    issue(4'd0, 32'd1, 32'd1, 32'h8, 32'h2000, 1'b1, 32'h2008, 4'd9);
    chk("full_reject_ready", 64'(in_ready), 64'd0);
    chk("full_head_tag0", 64'(out_tag), 64'd0);
    chk("full_head_pc0", 64'(next_pc), 64'h1008);
    pop();
    chk("pop1_head_tag1", 64'(out_tag), 64'd1);
    chk("pop1_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      set_in(4'd0, 32'd1, 32'd1, 32'h8, 32'h3000, 1'b1, 32'h3008, 4'(4 + i));
      in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      chk($sformatf("pp_head_tag_%0d", i), 64'(out_tag), 64'(2 + i));
      chk($sformatf("pp_count_kept_%0d", i), 64'({out_valid, in_ready}), 64'b11);
    end
    pop();
    chk("wrap_head_tag5", 64'(out_tag), 64'd5);
    set_in(4'd0, 32'd1, 32'd1, 32'h8, 32'h4000, 1'b1, 32'h4008, 4'd7);
    in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("flush_input_lost", 64'(out_valid), 64'd0);
    chk("flush_stats_br", 64'(br_cnt), 64'd12);
    chk("flush_stats_mp", 64'(mp_cnt), 64'd3);

    set_in(4'd0, 32'd1, 32'd1, 32'h8, 32'h5000, 1'b0, 32'h0, 4'd3);
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (21) tick();
    chk("sat_br", 64'(br_cnt), 64'd15);
    chk("sat_mp", 64'(mp_cnt), 64'd15);
    chk("sat_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_br", 64'(br_cnt), 64'd0);
    chk("async_rst_mp", 64'(mp_cnt), 64'd0);
    chk("async_rst_next_pc", 64'(next_pc), 64'd0);
    chk("async_rst_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_empty", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
